// File: rtl/fir_out_serializer.sv
// -----------------------------------------------------------------------------
// fir_out_serializer
//
// Purpose:
//   Output stage that sits behind the FIR core.
//   - Each wide filter result is accepted over a valid/ready handshake.
//   - Results are buffered in a small FIFO.
//   - Each result is then emitted MSB-first as a sequence of bytes.
//   - The consumer paces the bytes with a one-cycle byte_ack pulse.
//   - When byte_ack is held high, the output sustains one byte per cycle with
//     no gap between consecutive results.
//
// Build option:
//   FIR_OUT_SAT8_EN
//     When defined, each result is saturated to signed 8 bits as it is pushed.
//     FIFO entries then shrink to 8 bits, and every byte is the last byte of
//     its result.
//     When undefined, the full RES_W-bit result is serialized.
//
// Parameters:
//   RES_W  result width in bits (multiple of 8, 8..32)
//   DEPTH  FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset; discards all buffered data
//   res_data    signed FIR result
//   res_valid   result offered
//   res_ready   FIFO has room (derived from registered occupancy only)
//   byte_out    current output byte (0 while idle)
//   byte_valid  byte_out holds a valid byte
//   byte_last   byte_out is the final (LSB) byte of its result
//   byte_ack    consumer took byte_out (one-cycle pulse, already synchronous)
//   overflow    sticky: a result was offered while the FIFO was full
//   level       FIFO occupancy
// -----------------------------------------------------------------------------
module fir_out_serializer #(
  parameter int RES_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RES_W-1:0]           res_data,
  input  logic                       res_valid,
  output logic                       res_ready,
  output logic [7:0]                 byte_out,
  output logic                       byte_valid,
  output logic                       byte_last,
  input  logic                       byte_ack,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     level
);

`ifdef FIR_OUT_SAT8_EN
  localparam int ENT_W = 8;
  localparam int NB    = 1;
`else
  localparam int ENT_W = RES_W;
  localparam int NB    = RES_W / 8;
`endif
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state_reg, state_next;
  logic [ENT_W-1:0]       mem [DEPTH];
  logic [AW-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]       level_reg;
  logic [ENT_W-1:0]       shift_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   overflow_reg;

  logic                   push, pop, shift;
  logic [ENT_W-1:0]       push_data;

  // ---------------------------------------------------------------------------
  // Entry formatting at push time
  // ---------------------------------------------------------------------------
`ifdef FIR_OUT_SAT8_EN
  localparam logic signed [RES_W-1:0] SAT_HI = RES_W'(127);
  localparam logic signed [RES_W-1:0] SAT_LO = RES_W'(-128);

  always_comb begin
    push_data = res_data[7:0];
    if ($signed(res_data) > SAT_HI) begin
      push_data = 8'h7F;
    end else if ($signed(res_data) < SAT_LO) begin
      push_data = 8'h80;
    end
  end
`else
  assign push_data = res_data;
`endif

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // res_ready depends only on registered occupancy.
  // As a result, a pop that frees a full FIFO only admits a new push on the
  // following cycle.
  assign res_ready = (level_reg != LVL_W'(DEPTH));
  assign push      = res_valid && res_ready;

  // ---------------------------------------------------------------------------
  // FSM next state / control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    shift      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (level_reg != '0) begin
          pop        = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (byte_ack) begin
          if (cnt_reg != '0) begin
            shift = 1'b1;
          end else if (level_reg != '0) begin
            // Reload straight from the FIFO so the next result follows
            // without an idle cycle.
            pop = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage (no reset on the array; pointers and level define validity)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
      if (res_valid && !res_ready) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Byte shifter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (pop) begin
      shift_reg <= mem[rd_ptr_reg];
      cnt_reg   <= CNT_W'(NB - 1);
    end else if (shift) begin
      shift_reg <= shift_reg << 8;
      cnt_reg   <= cnt_reg - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign byte_valid = (state_reg == SEND);
  assign byte_out   = byte_valid ? shift_reg[ENT_W-1 -: 8] : 8'h00;
  assign byte_last  = byte_valid && (cnt_reg == '0);
  assign overflow   = overflow_reg;
  assign level      = level_reg;

endmodule

// File: tb/tb_fir_out_serializer.sv
// -----------------------------------------------------------------------------
// tb_fir_out_serializer
//
// Directed bench for fir_out_serializer with RES_W=16 and DEPTH=4.
// - Inputs change 1 time unit after each rising edge.
// - Outputs are checked at that same point, i.e. they reflect the state left
//   by the edge just taken.
// -----------------------------------------------------------------------------
module tb_fir_out_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ack;
  logic        overflow;
  logic [2:0]  level;

  int vectors     = 0;
  int miscompares = 0;

  fir_out_serializer #(.RES_W(16), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .byte_ack   (byte_ack),
    .overflow   (overflow),
    .level      (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check one presented byte: valid, value and last flag.
  task automatic chk_byte(input string tag, input logic [7:0] exp_b, input logic exp_last);
    chk({tag, ".valid"}, 32'(byte_valid), 32'd1);
    chk({tag, ".byte"},  32'(byte_out),   32'(exp_b));
    chk({tag, ".last"},  32'(byte_last),  32'(exp_last));
    $display("byte %s: out=%02h last=%0b", tag, byte_out, byte_last);
  endtask

`ifndef FIR_OUT_SAT8_EN
  logic [7:0] stall_seq [10] = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00,
                                 8'h03, 8'h00, 8'h04, 8'h00, 8'h05};
  logic [7:0] b2b_seq [4]    = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
`endif

  initial begin
    // ---------------- reset with a result offered ----------------
    rst = 1'b1; res_valid = 1'b1; res_data = 16'h5555; byte_ack = 1'b0;
    tick();
    tick();
    chk("rst.byte_valid", 32'(byte_valid), 32'd0);
    chk("rst.byte_out",   32'(byte_out),   32'd0);
    chk("rst.byte_last",  32'(byte_last),  32'd0);
    chk("rst.overflow",   32'(overflow),   32'd0);
    chk("rst.level",      32'(level),      32'd0);
    chk("rst.res_ready",  32'(res_ready),  32'd1);
    $display("reset: level=%0d ready=%0b", level, res_ready);
    rst = 1'b0; res_valid = 1'b0;

`ifndef FIR_OUT_SAT8_EN
    // ---------------- single result, ack held ----------------
    res_data = 16'h1234; res_valid = 1'b1; byte_ack = 1'b1;
    tick();                                   // push
    res_valid = 1'b0;
    chk("single.level_push", 32'(level), 32'd1);
    chk("single.not_yet_valid", 32'(byte_valid), 32'd0);
    tick();                                   // pop
    chk("single.level_pop", 32'(level), 32'd0);
    chk_byte("single.b0", 8'h12, 1'b0);
    tick();
    chk_byte("single.b1", 8'h34, 1'b1);
    tick();
    chk("single.done_valid", 32'(byte_valid), 32'd0);
    chk("single.done_byte",  32'(byte_out),   32'd0);
    chk("single.done_level", 32'(level),      32'd0);
    byte_ack = 1'b0;

    // ---------------- stalled consumer, overflow ----------------
    res_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      res_data = 16'(i);
      tick();
      if (i == 5) begin
        chk("stall.level_full", 32'(level),     32'd4);
        chk("stall.ready_low",  32'(res_ready), 32'd0);
        chk("stall.no_ovf_yet", 32'(overflow),  32'd0);
      end
    end
    res_valid = 1'b0;
    chk("stall.overflow",    32'(overflow), 32'd1);
    chk("stall.level_keep",  32'(level),    32'd4);
    chk_byte("stall.hold", 8'h00, 1'b0);
    byte_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk_byte($sformatf("stall.b%0d", i), stall_seq[i], 1'((i % 2) == 1));
      tick();
    end
    chk("stall.no_sixth", 32'(byte_valid), 32'd0);
    chk("stall.level_end", 32'(level), 32'd0);
    chk("stall.ovf_sticky", 32'(overflow), 32'd1);
    byte_ack = 1'b0;

    // ---------------- back-to-back results ----------------
    res_valid = 1'b1; res_data = 16'hAABB;
    tick();
    res_data = 16'hCCDD;
    tick();
    res_valid = 1'b0;
    chk("b2b.level", 32'(level), 32'd1);
    byte_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_byte($sformatf("b2b.b%0d", i), b2b_seq[i], 1'((i % 2) == 1));
      tick();
    end
    chk("b2b.end_valid", 32'(byte_valid), 32'd0);
    byte_ack = 1'b0;

    // ---------------- reset mid-transfer ----------------
    res_valid = 1'b1; res_data = 16'h1234;
    tick();
    res_valid = 1'b0;
    tick();
    chk_byte("midrst.b0", 8'h12, 1'b0);
    byte_ack = 1'b1;
    tick();
    chk_byte("midrst.b1_shown", 8'h34, 1'b1);
    byte_ack = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.valid",    32'(byte_valid), 32'd0);
    chk("midrst.byte",     32'(byte_out),   32'd0);
    chk("midrst.overflow", 32'(overflow),   32'd0);
    chk("midrst.level",    32'(level),      32'd0);
    byte_ack = 1'b1;
    tick();
    chk("midrst.stay_idle", 32'(byte_valid), 32'd0);
    byte_ack = 1'b0;
`else
    // ---------------- saturation to signed 8 bits ----------------
    byte_ack = 1'b1; res_valid = 1'b1; res_data = 16'h0100;
    tick();
    res_data = 16'hFE00;
    tick();
    chk_byte("sat.pos", 8'h7F, 1'b1);
    res_data = 16'h0042;
    tick();
    res_valid = 1'b0;
    chk_byte("sat.neg", 8'h80, 1'b1);
    tick();
    chk_byte("sat.pass", 8'h42, 1'b1);
    tick();
    chk("sat.end_valid", 32'(byte_valid), 32'd0);
    byte_ack = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fir_out_serializer.md
Name: fir_out_serializer

Overview:
- Downstream stage of the FIR core FSM.
- Accepts each wide filter result over a valid/ready handshake and buffers it in a small FIFO.
- Emits each result as a sequence of bytes, MSB first, on an 8-bit output bus. The tester/host paces the bytes with a byte_ack strobe, so the FIR core never waits on the slow pin interface until the FIFO fills.

Parameters:
- RES_W, 16, result width in bits; multiple of 8, range 8..32. NB = RES_W/8 bytes per result.
- DEPTH, 4, FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- res_data  in  RES_W  signed FIR result from core.
- res_valid  in  1  result valid.
- res_ready  out  1  FIFO can accept.
- byte_out  out  8  current output byte.
- byte_valid  out  1  byte_out holds a valid byte.
- byte_last  out  1  byte_out is the final (LSB) byte of a result.
- byte_ack  in  1  consumer took byte_out; already synchronized, one-cycle pulse.
- overflow  out  1  sticky: result offered while FIFO full.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset:
  - byte_out=0, byte_valid=0, byte_last=0, overflow=0, level=0, res_ready=1.
  - FIFO pointers cleared; FSM to IDLE.
  - Reset mid-transfer discards all buffered and in-flight data.
- FIFO:
  - res_ready = (level != DEPTH), registered-state derived, no combinational path from byte_ack.
  - Push on res_valid && res_ready. Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave level unchanged.
  - A pop freeing the full FIFO does not enable a same-cycle push.
- Overflow:
  - res_valid && !res_ready sets overflow (sticky until rst). The offered result is dropped; FIFO contents are unaffected.
- FSM states: IDLE, SEND.
  - IDLE: if level>0, pop head into shift register (RES_W bits) and load byte counter = NB-1 → SEND. byte_valid asserts the cycle after the pop.
  - SEND:
    - byte_out = shift_reg[RES_W-1 -: 8]; byte_valid=1; byte_last = (counter==0).
    - On byte_ack with counter>0: shift left 8, decrement counter; next byte valid the following cycle, no bubble.
    - On byte_ack with counter==0: if level>0, pop the next result in the same cycle and stay in SEND (back-to-back, no gap). Otherwise → IDLE, with byte_valid=0 next cycle.
  - byte_ack while byte_valid=0 is ignored.
  - byte_out holds its value while awaiting ack; it returns to 0 in IDLE.
- Latency: a result pushed on edge N into an empty FIFO with the FSM in IDLE is popped on edge N+1. Its first byte is valid after edge N+1.
- Throughput: one byte per cycle when byte_ack is held high continuously.
- Arithmetic: bytes are raw two's-complement slices; no sign manipulation without the optional feature.

Optional Feature:
- Macro FIR_OUT_SAT8_EN.
- Defined:
  - Each result is saturated to signed 8 bits at push time: >127 → 0x7F, <-128 → 0x80, else low byte.
  - FIFO entries are 8 bits; NB is forced to 1, so byte_last=1 on every byte.
- Undefined: full RES_W serialization as above.

Test Plan:
- Reset values: assert rst for 2 cycles with res_valid=1 → all outputs at reset values, level=0, no push accepted during rst.
- Single result: push 0x1234 (RES_W=16) while idle, byte_ack held 1 → byte_out 0x12 (last=0) then 0x34 (last=1) in consecutive cycles; byte_valid low after; level returns 0.
- Stalled consumer and overflow: byte_ack=0, push 0x0001,0x0002,0x0003,0x0004,0x0005,0x0006 on consecutive cycles → first pops to shift reg, next 4 fill FIFO, res_ready=0, 6th sets overflow=1. Then ack continuously → bytes 00 01 00 02 00 03 00 04 00 05, 0x0006 absent.
- Back-to-back: FIFO holds 0xAABB,0xCCDD, byte_ack=1 → bytes AA BB CC DD with byte_valid continuous, no gap.
- Reset mid-transfer: after byte 0x12 of 0x1234 acked, pulse rst → byte_valid=0 next cycle, 0x34 never emitted, overflow cleared.
- FIR_OUT_SAT8_EN: push 0x0100, 0xFE00, 0x0042 → bytes 7F, 80, 42, each with byte_last=1.
